ysyx_25050148_lsu: RTL and testbench
====================================

# ysyx_25050148_lsu

Load/store unit that sits between the execute stage and the data-memory port of the multi-cycle core. It accepts one load or store per handshake, aligns store data and generates byte strobes. It drives a valid/ready request/response bus toward memory and waits for a variable-latency response. For loads, it shifts and sign- or zero-extends the returned word before handing the result back upstream. Misaligned accesses are rejected locally without touching memory.

## Interface
- No parameters; all widths fixed at 32-bit address/data.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_len  in  2  access size: 0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wen  out  1  registered copy of req_wen.
- mem_req_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_req_wdata  out  32  store data shifted to its byte lane.
- mem_req_wmask  out  4  byte strobes; 4'b0000 for loads.
- mem_rsp_valid  in  1  memory response valid; this is the read data or the write ack.
- mem_rsp_ready  out  1  LSU accepts a response; high only in WAIT.
- mem_rsp_rdata  in  32  aligned word read from memory.
- out_valid  out  1  result valid.
- out_ready  in  1  upstream consumes the result.
- out_rdata  out  32  extended load data; 0 for stores and for errors.
- out_err  out  1  misaligned access.

## Operation
- States: IDLE, REQ, WAIT, DONE. Encoding is free.
- IDLE:
  - req_ready=1.
  - On req_valid, latch wen, addr[1:0], len and signed.
  - If misaligned (len=1 with addr[0]=1, or len>=2 with addr[1:0]!=0): set err, out_rdata=0, go to DONE.
  - Otherwise go to REQ.
- Store formatting:
  - wdata = req_wdata << (8*addr[1:0]).
  - wmask = {0001, 0011, 1111}[len] << addr[1:0]; only the low 4 bits are kept.
- REQ: mem_req_valid=1, with addr/wen/wdata/wmask held stable. On mem_req_ready, go to WAIT.
- WAIT: mem_rsp_ready=1. On mem_rsp_valid, go to DONE.
  - Load: out_rdata = extend(mem_rsp_rdata >> (8*off), len, signed). Size 1 extends bit 7, size 2 extends bit 15, size 4 passes through.
  - Store: out_rdata=0.
- DONE: out_valid=1, with out_rdata/out_err held. On out_ready, go to IDLE and clear err.
- No request pipelining: at most one outstanding transaction.

## Timing
- Reset: state=IDLE.
  - req_ready=1.
  - mem_req_valid=0, mem_rsp_ready=0, out_valid=0.
  - out_rdata=0, out_err=0, mem_req_wmask=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wen=0.
- Minimum latency, with ready/valid asserted as early as possible:
  - Request accepted at edge of cycle 0.
  - mem_req_valid high in cycle 1.
  - mem_rsp_ready high in cycle 2.
  - out_valid high in cycle 3.
- Misaligned access: out_valid high in cycle 1; mem_req_valid never asserted.
- All outputs are registered or decoded from state only; there is no combinational path from mem_* or out_ready to req_ready.
- Backpressure:
  - mem_req_ready low: hold REQ indefinitely with outputs stable.
  - out_ready low: hold DONE indefinitely.
- mem_rsp_valid outside WAIT is ignored and does not change state.
- Reset mid-transaction returns to IDLE next edge. A late memory response is then dropped because mem_rsp_ready=0 in IDLE.
- req_valid while not in IDLE is ignored; req_ready=0.

## Test plan
- Load byte, signed: addr=0x80000003, len=0, signed=1, rsp_rdata=0x80AB_CDEF -> mem_req_addr=0x80000000, wmask=0, out_rdata=0xFFFF_FF80.
- Load half, unsigned: addr=0x80000002, len=1, signed=0, rsp=0x9234_5678 -> out_rdata=0x0000_9234. Repeat with signed=1 -> 0xFFFF_9234.
- Store half: addr=0x80000006, len=1, wdata=0x1234_ABCD -> mem_req_addr=0x80000004, wdata=0xABCD_0000, wmask=4'b1100. After ack, out_rdata=0, out_err=0.
- Misaligned word: addr=0x80000002, len=2 -> mem_req_valid stays 0, out_valid in cycle 1, out_err=1. Next request is accepted after out_ready.
- Backpressure: hold mem_req_ready=0 for 5 cycles, then rsp delayed 3 cycles, then out_ready=0 for 2 cycles -> outputs stable throughout, exactly one result.
- Reset in WAIT, then rsp_valid pulse -> state IDLE, pulse ignored, out_valid stays 0, req_ready=1.

Source files
------------

// File: rtl/ysyx_25050148_lsu.sv
// Load/store unit between execute and the data-memory port.
// Formats stores, extends loads and traps misaligned accesses.
module ysyx_25050148_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_len,
    input  logic        req_signed,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [1:0]  len_q;
    logic        sgn_q;
    logic        misal;
    logic [3:0]  base_mask;
    logic [31:0] sh_rdata;
    logic [31:0] ext_rdata;

    assign req_ready     = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign mem_rsp_ready = (state == WAIT);
    assign out_valid     = (state == DONE);

    always_comb begin
        misal = 1'b0;
        if (req_len == 2'd1 && req_addr[0])
            misal = 1'b1;
        if (req_len[1] && req_addr[1:0] != 2'b00)
            misal = 1'b1;
    end

    always_comb begin
        case (req_len)
            2'd0:    base_mask = 4'b0001;
            2'd1:    base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
    end

    // Move the addressed lane down to bit 0, then extend by access size.
    assign sh_rdata = mem_rsp_rdata >> {off_q, 3'b000};

    always_comb begin
        case (len_q)
            2'd0:    ext_rdata = {{24{sgn_q & sh_rdata[7]}}, sh_rdata[7:0]};
            2'd1:    ext_rdata = {{16{sgn_q & sh_rdata[15]}}, sh_rdata[15:0]};
            default: ext_rdata = sh_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            off_q         <= 2'b00;
            len_q         <= 2'b00;
            sgn_q         <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= 32'h0;
            mem_req_wdata <= 32'h0;
            mem_req_wmask <= 4'b0000;
            out_rdata     <= 32'h0;
            out_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q     <= req_addr[1:0];
                        len_q     <= req_len;
                        sgn_q     <= req_signed;
                        out_rdata <= 32'h0;
                        if (misal) begin
                            out_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            mem_req_wen   <= req_wen;
                            mem_req_addr  <= {req_addr[31:2], 2'b00};
                            mem_req_wdata <= req_wdata << {req_addr[1:0], 3'b000};
                            mem_req_wmask <= req_wen ? (base_mask << req_addr[1:0])
                                                     : 4'b0000;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready)
                        state <= WAIT;
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        out_rdata <= mem_req_wen ? 32'h0 : ext_rdata;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_err <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25050148_lsu.sv
// Directed bench for the load/store unit.
// Inputs are driven and outputs sampled on the falling edge.
module tb_ysyx_25050148_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_len;
    logic        req_signed;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_25050148_lsu dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_wen       (req_wen),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_len       (req_len),
        .req_signed    (req_signed),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_wen   (mem_req_wen),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_rdata (mem_rsp_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_err       (out_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] len,
                         input logic sgn);
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wdata;
        req_len    = len;
        req_signed = sgn;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    // Full minimum-latency transaction with exact per-cycle checks.
    task automatic txn(input string nm, input logic wen,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] len, input logic sgn,
                       input logic [31:0] rsp, input logic [31:0] e_addr,
                       input logic [31:0] e_wdata, input logic [3:0] e_mask,
                       input logic [31:0] e_rdata);
        issue(wen, addr, wdata, len, sgn);
        chk({nm, "_c1_mvalid"}, {31'b0, mem_req_valid}, 32'd1);
        chk({nm, "_c1_ovalid"}, {31'b0, out_valid}, 32'd0);
        chk({nm, "_addr"}, mem_req_addr, e_addr);
        chk({nm, "_wen"}, {31'b0, mem_req_wen}, {31'b0, wen});
        chk({nm, "_mask"}, {28'b0, mem_req_wmask}, {28'b0, e_mask});
        if (wen)
            chk({nm, "_wdata"}, mem_req_wdata, e_wdata);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk({nm, "_c2_rready"}, {31'b0, mem_rsp_ready}, 32'd1);
        chk({nm, "_c2_mvalid"}, {31'b0, mem_req_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rsp;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk({nm, "_c3_ovalid"}, {31'b0, out_valid}, 32'd1);
        chk({nm, "_rdata"}, out_rdata, e_rdata);
        chk({nm, "_err"}, {31'b0, out_err}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_back_idle"}, {31'b0, out_valid}, 32'd0);
    endtask

    task automatic misal_txn(input string nm, input logic [31:0] addr,
                             input logic [1:0] len);
        issue(1'b0, addr, 32'h0, len, 1'b0);
        chk({nm, "_mvalid"}, {31'b0, mem_req_valid}, 32'd0);
        chk({nm, "_ovalid"}, {31'b0, out_valid}, 32'd1);
        chk({nm, "_err"}, {31'b0, out_err}, 32'd1);
        chk({nm, "_rdata"}, out_rdata, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_ready"}, {31'b0, req_ready}, 32'd1);
        chk({nm, "_errclr"}, {31'b0, out_err}, 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_wen       = 1'b0;
        req_addr      = 32'h0;
        req_wdata     = 32'h0;
        req_len       = 2'd0;
        req_signed    = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 32'h0;
        out_ready     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mvalid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_rready", {31'b0, mem_rsp_ready}, 32'd0);
        chk("rst_ovalid", {31'b0, out_valid}, 32'd0);
        chk("rst_rdata", out_rdata, 32'h0);
        chk("rst_err", {31'b0, out_err}, 32'd0);
        chk("rst_mask", {28'b0, mem_req_wmask}, 32'h0);
        chk("rst_addr", mem_req_addr, 32'h0);
        chk("rst_wdata", mem_req_wdata, 32'h0);
        chk("rst_wen", {31'b0, mem_req_wen}, 32'd0);

        txn("lb", 1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 32'h80AB_CDEF,
            32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80);
        txn("lbu", 1'b0, 32'h8000_0001, 32'h0, 2'd0, 1'b0, 32'h80AB_CDEF,
            32'h8000_0000, 32'h0, 4'b0000, 32'h0000_00CD);
        txn("lhu", 1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 32'h9234_5678,
            32'h8000_0000, 32'h0, 4'b0000, 32'h0000_9234);
        txn("lh", 1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 32'h9234_5678,
            32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_9234);
        txn("lh0", 1'b0, 32'h8000_0000, 32'h0, 2'd1, 1'b1, 32'h9234_5678,
            32'h8000_0000, 32'h0, 4'b0000, 32'h0000_5678);
        txn("lw", 1'b0, 32'h8000_0008, 32'h0, 2'd3, 1'b1, 32'hCAFE_F00D,
            32'h8000_0008, 32'h0, 4'b0000, 32'hCAFE_F00D);
        txn("sh", 1'b1, 32'h8000_0006, 32'h1234_ABCD, 2'd1, 1'b0,
            32'h5555_5555, 32'h8000_0004, 32'hABCD_0000, 4'b1100, 32'h0);
        txn("sb", 1'b1, 32'h8000_0011, 32'h0000_00A5, 2'd0, 1'b0,
            32'h5555_5555, 32'h8000_0010, 32'h0000_A500, 4'b0010, 32'h0);
        txn("sw", 1'b1, 32'h8000_0020, 32'h0BAD_BEEF, 2'd2, 1'b0,
            32'h5555_5555, 32'h8000_0020, 32'h0BAD_BEEF, 4'b1111, 32'h0);

        misal_txn("mis_w", 32'h8000_0002, 2'd2);
        misal_txn("mis_h", 32'h8000_0001, 2'd1);
        txn("after_mis", 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'h1357_9BDF,
            32'h8000_0004, 32'h0, 4'b0000, 32'h1357_9BDF);

        // Backpressure on every handshake.
        issue(1'b0, 32'h8000_0031, 32'h0, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_hold", {31'b0, mem_req_valid}, 32'd1);
            chk("bp_addr_hold", mem_req_addr, 32'h8000_0030);
            chk("bp_nordy", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        chk("bp_req_hold5", {31'b0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_wait", {31'b0, mem_rsp_ready}, 32'd1);
            chk("bp_wait_ov", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h1122_7F44;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bp_done_ov", {31'b0, out_valid}, 32'd1);
            chk("bp_done_rd", out_rdata, 32'h0000_007F);
            @(negedge clk);
        end
        chk("bp_done_ov2", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("bp_one_result", {31'b0, out_valid}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;

        // Reset while waiting for the response, then a late response.
        issue(1'b0, 32'h8000_0040, 32'h0, 2'd2, 1'b0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rw_in_wait", {31'b0, mem_rsp_ready}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rw_idle", {31'b0, req_ready}, 32'd1);
        chk("rw_rready0", {31'b0, mem_rsp_ready}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("rw_ov0", {31'b0, out_valid}, 32'd0);
        chk("rw_ready", {31'b0, req_ready}, 32'd1);
        chk("rw_rdata0", out_rdata, 32'h0);
        @(negedge clk);
        chk("rw_ov0b", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
